motor_cmd_sequencer: RTL and testbench
======================================

Name: motor_cmd_sequencer

Overview:
- Sits between the line-follow steering logic and motor_control.
- Accepts signed left/right speed commands over a valid/ready handshake.
- Slews the lft/rht values fed to motor_control by a fixed step per update tick. Any direction reversal passes through zero and holds zero for a dead time, so the H-bridge never sees an instantaneous fwd/rev swap.
- An e-stop input forces both wheels to zero immediately.

Parameters:
W, 11, width of signed speed values (matches motor_control lft/rht)
STEP, 16, magnitude change per tick per wheel
TICK_DIV, 1000, clk cycles per update tick (>=2)
DEAD_TICKS, 4, ticks a wheel holds zero before reversing direction (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
cmd_vld  input  1  command valid
cmd_rdy  output  1  block accepts a command this cycle
cmd_lft  input  W  requested left speed, two's complement
cmd_rht  input  W  requested right speed, two's complement
estop  input  1  emergency stop, level-sensitive
lft  output  W  registered left speed to motor_control
rht  output  W  registered right speed to motor_control
busy  output  1  a wheel is ramping or in dead time
at_target  output  1  both wheels at target, not in e-stop

Behaviour:
- Reset values:
  - lft=rht=0; targets tgt_l=tgt_r=0; tick counter 0.
  - Both wheel FSMs RUN; top FSM NORMAL.
  - cmd_rdy=1, busy=0, at_target=1.
- Tick counter:
  - Free-running 0..TICK_DIV-1, wraps to 0.
  - tick=1 in the cycle where count==TICK_DIV-1.
  - The counter is not affected by commands or estop.
- Command accept:
  - A command is accepted on the cycle with cmd_vld&cmd_rdy.
  - Each field is saturated to [-(2^(W-1)-1), +(2^(W-1)-1)], so -1024 becomes -1023.
  - Saturated values are stored in tgt_l/tgt_r at that edge.
  - cmd_rdy = (top FSM==NORMAL). No queueing: a later accept overwrites the targets.
  - If accept and tick occur in the same cycle, the tick uses the old targets; the new targets apply from the next tick.
- Wheel FSM (independent per wheel; cur = lft or rht; updates only on tick edges):
  - RUN, cur!=0, tgt!=0, sign(cur)!=sign(tgt):
    - cur moves STEP toward 0, clamped at 0 (never crosses zero).
    - If the result is 0, go to DEAD with dcnt=DEAD_TICKS.
  - RUN otherwise: cur moves STEP toward tgt, clamped at tgt. cur==tgt means no change.
  - DEAD:
    - cur held at 0; dcnt decrements each tick.
    - On the tick where dcnt==1, go to RUN with cur still 0. Ramping resumes on the following tick.
    - Total zero-hold is DEAD_TICKS ticks after reaching zero.
    - Target changes during DEAD do not shorten the dead time.
  - Targeting 0 from any nonzero value ramps to 0 with no DEAD entry.
  - Arithmetic is done in W+1 bits, then clamped. Results never exceed ±(2^(W-1)-1).
- Top FSM:
  - NORMAL -> ESTOP when estop=1. Edge effects:
    - lft=rht=0, tgt_l=tgt_r=0, wheels forced to RUN, dcnt cleared.
    - estop has priority over tick and over a command accept in the same cycle.
  - ESTOP: outputs held at 0, cmd_rdy=0, commands ignored.
  - ESTOP -> NORMAL on the first edge with estop=0. Targets remain 0 until a new command.
- Status outputs:
  - busy = (lft!=tgt_l) | (rht!=tgt_r) | any wheel in DEAD.
  - at_target = ~busy & (top FSM==NORMAL).
  - Both are combinational from registers.
- rst during DEAD or a ramp returns everything to reset values at that edge.

Test Plan:
All cases use TICK_DIV=4, STEP=16, DEAD_TICKS=2.
1. Reset:
   - Stimulus: hold rst 2 cycles, then release.
   - Required: lft=rht=0, cmd_rdy=1, busy=0, at_target=1.
2. Forward ramp:
   - Stimulus: cmd (100,100) accepted.
   - Required: lft/rht step 16,32,48,64,80,96,100 on successive ticks; busy drops and at_target rises after the 7th tick; values stay at 100.
3. Reversal:
   - Stimulus: from (100,100), cmd (100,-102).
   - Required: lft constant. rht steps 84,68,52,36,20,4,0, holds 0 for 2 ticks, then -16..-96,-102. busy=1 throughout.
4. E-stop mid-ramp:
   - Stimulus: assert estop while rht=-48.
   - Required: lft=rht=0 next edge, cmd_rdy=0, a cmd_vld pulse is ignored. After release, cmd_rdy=1 and outputs stay 0 until a new command.
5. Saturation:
   - Stimulus: cmd (-1024,1023).
   - Required: targets -1023/+1023, reached exactly with no overflow. Final step sizes are 15 on both wheels.
6. Corners:
   - Stimulus A: cmd accepted on a tick cycle.
   - Required A: first step goes toward the old target; the next tick goes toward the new one.
   - Stimulus B: rst asserted mid-DEAD.
   - Required B: reset values on the next edge; no residual dead time on the next reversal.

Source files
------------

// File: rtl/motor_cmd_sequencer.sv
// Motor command sequencer: accepts signed left/right speed commands, slews the
// wheel speeds toward them a fixed step per update tick, inserts a zero-speed
// dead time on every direction reversal, and forces zero on emergency stop.
module motor_cmd_sequencer #(
  parameter int W          = 11,
  parameter int STEP       = 16,
  parameter int TICK_DIV   = 1000,
  parameter int DEAD_TICKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_vld,
  output logic                cmd_rdy,
  input  logic signed [W-1:0] cmd_lft,
  input  logic signed [W-1:0] cmd_rht,
  input  logic                estop,
  output logic signed [W-1:0] lft,
  output logic signed [W-1:0] rht,
  output logic                busy,
  output logic                at_target
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEAD_TICKS + 1);

  // Step size widened by one bit so ramp arithmetic cannot wrap.
  localparam logic signed [W:0]   STEP_X   = (W+1)'(STEP);
  // Largest legal magnitude and the one code that has no positive mirror.
  localparam logic signed [W-1:0] MAX_V    = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V    = -MAX_V;
  localparam logic signed [W-1:0] NEG_FULL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {TOP_NORMAL, TOP_ESTOP} top_t;
  typedef enum logic {WHL_RUN, WHL_DEAD} whl_t;

  // Fold the most negative code onto -MAX_V so commands are symmetric.
  function automatic logic signed [W-1:0] sat_cmd(input logic signed [W-1:0] v);
    logic signed [W-1:0] r;
    r = v;
    if (v == NEG_FULL) r = MIN_V;
    return r;
  endfunction

  // Move cur one STEP toward tgt without overshooting it.
  function automatic logic signed [W-1:0] ramp_to(input logic signed [W-1:0] cur,
                                                 input logic signed [W-1:0] tgt);
    logic signed [W:0] c;
    logic signed [W:0] t;
    logic signed [W:0] n;
    c = {cur[W-1], cur};
    t = {tgt[W-1], tgt};
    if (c < t) begin
      n = c + STEP_X;
      if (n > t) n = t;
    end else if (c > t) begin
      n = c - STEP_X;
      if (n < t) n = t;
    end else begin
      n = c;
    end
    return n[W-1:0];
  endfunction

  logic [CW-1:0]       cnt_q;
  logic                tick;
  top_t                top_q;
  top_t                top_d;
  logic                accept;

  logic signed [W-1:0] cmd_w  [2];
  logic signed [W-1:0] cur_q  [2];
  logic signed [W-1:0] cur_d  [2];
  logic signed [W-1:0] tgt_q  [2];
  logic signed [W-1:0] tgt_d  [2];
  whl_t                wst_q  [2];
  whl_t                wst_d  [2];
  logic [DW-1:0]       dcnt_q [2];
  logic [DW-1:0]       dcnt_d [2];

  assign tick     = (cnt_q == CW'(TICK_DIV - 1));
  assign cmd_rdy  = (top_q == TOP_NORMAL);
  assign accept   = cmd_vld & cmd_rdy & ~estop;
  assign cmd_w[0] = cmd_lft;
  assign cmd_w[1] = cmd_rht;

  // Free-running update-tick divider, only cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Top-level e-stop state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q <= TOP_NORMAL;
    end else begin
      top_q <= top_d;
    end
  end

  // Top-level next state: e-stop is held while the input is high.
  always_comb begin
    top_d = top_q;
    case (top_q)
      TOP_NORMAL: if (estop)  top_d = TOP_ESTOP;
      TOP_ESTOP:  if (!estop) top_d = TOP_NORMAL;
      default:    top_d = TOP_NORMAL;
    endcase
  end

  // Per-wheel next state: ramp or dead-time on ticks, target load on accept,
  // e-stop overriding both so it wins over anything else in the same cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cur_d[i]  = cur_q[i];
      tgt_d[i]  = tgt_q[i];
      wst_d[i]  = wst_q[i];
      dcnt_d[i] = dcnt_q[i];

      if (tick) begin
        case (wst_q[i])
          WHL_RUN: begin
            if ((cur_q[i] != '0) && (tgt_q[i] != '0) &&
                (cur_q[i][W-1] != tgt_q[i][W-1])) begin
              // Reversal pending: come down to zero first, never cross it.
              cur_d[i] = ramp_to(cur_q[i], '0);
              if (ramp_to(cur_q[i], '0) == '0) begin
                wst_d[i]  = WHL_DEAD;
                dcnt_d[i] = DW'(DEAD_TICKS);
              end
            end else begin
              cur_d[i] = ramp_to(cur_q[i], tgt_q[i]);
            end
          end
          WHL_DEAD: begin
            cur_d[i] = '0;
            if (dcnt_q[i] == DW'(1)) begin
              wst_d[i]  = WHL_RUN;
              dcnt_d[i] = '0;
            end else begin
              dcnt_d[i] = dcnt_q[i] - DW'(1);
            end
          end
          default: wst_d[i] = WHL_RUN;
        endcase
      end

      // The tick above used the old target; a new one applies from next tick.
      if (accept) tgt_d[i] = sat_cmd(cmd_w[i]);

      if (estop) begin
        cur_d[i]  = '0;
        tgt_d[i]  = '0;
        wst_d[i]  = WHL_RUN;
        dcnt_d[i] = '0;
      end
    end
  end

  // Per-wheel state registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        cur_q[i]  <= '0;
        tgt_q[i]  <= '0;
        wst_q[i]  <= WHL_RUN;
        dcnt_q[i] <= '0;
      end else begin
        cur_q[i]  <= cur_d[i];
        tgt_q[i]  <= tgt_d[i];
        wst_q[i]  <= wst_d[i];
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  assign lft       = cur_q[0];
  assign rht       = cur_q[1];
  assign busy      = (cur_q[0] != tgt_q[0]) | (cur_q[1] != tgt_q[1]) |
                     (wst_q[0] == WHL_DEAD) | (wst_q[1] == WHL_DEAD);
  assign at_target = ~busy & (top_q == TOP_NORMAL);

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer: directed scenarios with hand-derived
// expectations, then randomized traffic against an integer reference model.
module tb_motor_cmd_sequencer;

  localparam int W          = 11;
  localparam int STEP       = 16;
  localparam int TICK_DIV   = 4;
  localparam int DEAD_TICKS = 2;
  localparam int VMAX       = 1023;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_vld;
  logic                cmd_rdy;
  logic signed [W-1:0] cmd_lft;
  logic signed [W-1:0] cmd_rht;
  logic                estop;
  logic signed [W-1:0] lft;
  logic signed [W-1:0] rht;
  logic                busy;
  logic                at_target;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (plain integers).
  int m_cnt   = 0;
  int m_l     = 0;
  int m_r     = 0;
  int m_tl    = 0;
  int m_tr    = 0;
  int m_dl    = 0;   // remaining zero-hold ticks, left
  int m_dr    = 0;   // remaining zero-hold ticks, right
  int m_ticks = 0;
  bit m_es    = 1'b0;

  always #5 clk = ~clk;

  motor_cmd_sequencer #(
    .W(W), .STEP(STEP), .TICK_DIV(TICK_DIV), .DEAD_TICKS(DEAD_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_lft(cmd_lft), .cmd_rht(cmd_rht), .estop(estop),
    .lft(lft), .rht(rht), .busy(busy), .at_target(at_target)
  );

  function automatic int sat_ref(int v);
    if (v < -VMAX) return -VMAX;
    if (v > VMAX)  return VMAX;
    return v;
  endfunction

  function automatic int toward(int cur, int tgt);
    if (cur < tgt) return (cur + STEP > tgt) ? tgt : cur + STEP;
    if (cur > tgt) return (cur - STEP < tgt) ? tgt : cur - STEP;
    return cur;
  endfunction

  task automatic wheel_ref(inout int cur, input int tgt, inout int dead);
    if (dead > 0) begin
      dead = dead - 1;
      cur  = 0;
    end else if (cur != 0 && tgt != 0 && ((cur < 0) != (tgt < 0))) begin
      cur = toward(cur, 0);
      if (cur == 0) dead = DEAD_TICKS;
    end else begin
      cur = toward(cur, tgt);
    end
  endtask

  // Reference model advanced on every clock edge from the driven inputs.
  always @(posedge clk) begin
    bit tk;
    if (rst) begin
      m_cnt = 0; m_l = 0; m_r = 0; m_tl = 0; m_tr = 0;
      m_dl = 0; m_dr = 0; m_es = 1'b0;
    end else begin
      tk    = (m_cnt == TICK_DIV - 1);
      m_cnt = tk ? 0 : m_cnt + 1;
      if (tk) m_ticks = m_ticks + 1;
      if (estop) begin
        m_l = 0; m_r = 0; m_tl = 0; m_tr = 0; m_dl = 0; m_dr = 0;
        m_es = 1'b1;
      end else begin
        if (tk) begin
          wheel_ref(m_l, m_tl, m_dl);
          wheel_ref(m_r, m_tr, m_dr);
        end
        if (cmd_vld && !m_es) begin
          m_tl = sat_ref(int'(cmd_lft));
          m_tr = sat_ref(int'(cmd_rht));
        end
        m_es = 1'b0;
      end
    end
  end

  // Advance to the falling edge just after the next update tick.
  task automatic next_tick();
    int start;
    start = m_ticks;
    for (int k = 0; k < 4 * TICK_DIV; k++) begin
      @(negedge clk);
      if (m_ticks != start) return;
    end
    $display("FAIL next_tick: no tick seen, got %0d ticks, required %0d", m_ticks, start + 1);
    $fatal(1, "tick wait expired");
  endtask

  // Present one command for a single cycle (block is assumed ready).
  task automatic send_cmd(input int l, input int r);
    cmd_vld = 1'b1;
    cmd_lft = W'(l);
    cmd_rht = W'(r);
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_vld = 1'b0; estop = 1'b0; cmd_lft = '0; cmd_rht = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (lft !== 0 || rht !== 0 || cmd_rdy !== 1'b1 || busy !== 1'b0 || at_target !== 1'b1)
      $display("FAIL reset: lft=%0d rht=%0d rdy=%b busy=%b at=%b, required 0 0 1 0 1",
               lft, rht, cmd_rdy, busy, at_target);
    else n_pass++;
  endtask

  task automatic test_forward_ramp();
    int ev[7] = '{16, 32, 48, 64, 80, 96, 100};
    send_cmd(100, 100);
    n_checks++;
    if (busy !== 1'b1 || at_target !== 1'b0)
      $display("FAIL fwd_accept: busy=%b at=%b, required 1 0", busy, at_target);
    else n_pass++;
    for (int i = 0; i < 9; i++) begin
      int e;
      next_tick();
      e = (i < 7) ? ev[i] : 100;
      n_checks++;
      if (lft !== e || rht !== e || busy !== (i < 6) || at_target !== (i >= 6))
        $display("FAIL fwd_ramp tick %0d: lft=%0d rht=%0d busy=%b at=%b, required %0d %0d %b %b",
                 i + 1, lft, rht, busy, at_target, e, e, i < 6, i >= 6);
      else n_pass++;
    end
  endtask

  task automatic test_reversal();
    int ev[16] = '{84, 68, 52, 36, 20, 4, 0, 0, 0, -16, -32, -48, -64, -80, -96, -102};
    send_cmd(100, -102);
    for (int i = 0; i < 16; i++) begin
      next_tick();
      n_checks++;
      if (lft !== 100 || rht !== ev[i] || busy !== (i < 15))
        $display("FAIL reversal tick %0d: lft=%0d rht=%0d busy=%b, required 100 %0d %b",
                 i + 1, lft, rht, busy, ev[i], i < 15);
      else n_pass++;
    end
  endtask

  task automatic test_to_zero();
    send_cmd(0, 0);
    for (int k = 1; k <= 7; k++) begin
      int el;
      int er;
      next_tick();
      el = (100 - STEP * k > 0) ? 100 - STEP * k : 0;
      er = (-102 + STEP * k < 0) ? -102 + STEP * k : 0;
      n_checks++;
      if (lft !== el || rht !== er || busy !== (k < 7))
        $display("FAIL to_zero tick %0d: lft=%0d rht=%0d busy=%b, required %0d %0d %b",
                 k, lft, rht, busy, el, er, k < 7);
      else n_pass++;
    end
  endtask

  task automatic test_estop();
    send_cmd(0, -200);
    for (int k = 1; k <= 3; k++) begin
      next_tick();
      n_checks++;
      if (lft !== 0 || rht !== -STEP * k)
        $display("FAIL estop_pre tick %0d: lft=%0d rht=%0d, required 0 %0d", k, lft, rht, -STEP * k);
      else n_pass++;
    end
    // e-stop asserted together with a command: e-stop must win.
    estop = 1'b1; cmd_vld = 1'b1; cmd_lft = W'(50); cmd_rht = W'(50);
    @(negedge clk);
    n_checks++;
    if (lft !== 0 || rht !== 0 || cmd_rdy !== 1'b0 || busy !== 1'b0 || at_target !== 1'b0)
      $display("FAIL estop_hit: lft=%0d rht=%0d rdy=%b busy=%b at=%b, required 0 0 0 0 0",
               lft, rht, cmd_rdy, busy, at_target);
    else n_pass++;
    @(negedge clk);
    cmd_vld = 1'b0;
    next_tick();
    next_tick();
    n_checks++;
    if (lft !== 0 || rht !== 0 || cmd_rdy !== 1'b0)
      $display("FAIL estop_hold: lft=%0d rht=%0d rdy=%b, required 0 0 0", lft, rht, cmd_rdy);
    else n_pass++;
    estop = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_rdy !== 1'b1 || at_target !== 1'b1 || busy !== 1'b0)
      $display("FAIL estop_release: rdy=%b at=%b busy=%b, required 1 1 0", cmd_rdy, at_target, busy);
    else n_pass++;
    for (int k = 0; k < 3; k++) next_tick();
    n_checks++;
    if (lft !== 0 || rht !== 0)
      $display("FAIL estop_after: lft=%0d rht=%0d, required 0 0", lft, rht);
    else n_pass++;
  endtask

  task automatic test_saturation();
    send_cmd(-1024, 1023);
    for (int k = 1; k <= 65; k++) begin
      int e;
      next_tick();
      e = (STEP * k > VMAX) ? VMAX : STEP * k;
      n_checks++;
      if (lft !== -e || rht !== e || busy !== (k < 64))
        $display("FAIL saturation tick %0d: lft=%0d rht=%0d busy=%b, required %0d %0d %b",
                 k, lft, rht, busy, -e, e, k < 64);
      else n_pass++;
    end
  endtask

  task automatic test_tick_accept();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_cmd(48, 48);
    next_tick();
    next_tick();
    // Line the new command up with the tick edge.
    for (int k = 0; k < TICK_DIV && m_cnt != TICK_DIV - 1; k++) @(negedge clk);
    send_cmd(0, 0);
    n_checks++;
    if (lft !== 48 || rht !== 48 || busy !== 1'b1)
      $display("FAIL tick_accept first: lft=%0d rht=%0d busy=%b, required 48 48 1", lft, rht, busy);
    else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      next_tick();
      n_checks++;
      if (lft !== 48 - STEP * k || rht !== 48 - STEP * k)
        $display("FAIL tick_accept tick %0d: lft=%0d rht=%0d, required %0d",
                 k, lft, rht, 48 - STEP * k);
      else n_pass++;
    end
  endtask

  task automatic test_reset_dead();
    send_cmd(48, 48);
    for (int k = 0; k < 3; k++) next_tick();
    send_cmd(-48, 48);
    for (int k = 0; k < 4; k++) next_tick();
    n_checks++;
    if (lft !== 0 || rht !== 48 || busy !== 1'b1)
      $display("FAIL dead_hold: lft=%0d rht=%0d busy=%b, required 0 48 1", lft, rht, busy);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (lft !== 0 || rht !== 0 || cmd_rdy !== 1'b1 || busy !== 1'b0 || at_target !== 1'b1)
      $display("FAIL rst_dead: lft=%0d rht=%0d rdy=%b busy=%b at=%b, required 0 0 1 0 1",
               lft, rht, cmd_rdy, busy, at_target);
    else n_pass++;
    rst = 1'b0;
    send_cmd(-32, 0);
    next_tick();
    n_checks++;
    if (lft !== -16 || rht !== 0)
      $display("FAIL rst_dead_next: lft=%0d rht=%0d, required -16 0", lft, rht);
    else n_pass++;
  endtask

  task automatic test_random();
    int es_hold = 0;
    for (int c = 0; c < 1200; c++) begin
      bit exp_busy;
      @(negedge clk);
      exp_busy = (m_l != m_tl) || (m_r != m_tr) || (m_dl > 0) || (m_dr > 0);
      n_checks++;
      if (lft !== m_l || rht !== m_r || busy !== exp_busy ||
          at_target !== (!exp_busy && !m_es) || cmd_rdy !== !m_es)
        $display("FAIL random cyc %0d: lft=%0d rht=%0d busy=%b at=%b rdy=%b, required %0d %0d %b %b %b",
                 c, lft, rht, busy, at_target, cmd_rdy, m_l, m_r, exp_busy,
                 !exp_busy && !m_es, !m_es);
      else n_pass++;
      if (es_hold > 0) begin
        estop = 1'b1;
        es_hold--;
      end else begin
        estop = 1'b0;
        if ($urandom_range(0, 79) == 0) es_hold = $urandom_range(1, 6);
      end
      cmd_vld = ($urandom_range(0, 11) == 0);
      for (int w = 0; w < 2; w++) begin
        int v;
        case ($urandom_range(0, 5))
          0:       v = -1024;
          1:       v = 1023;
          2:       v = 0;
          default: v = int'($urandom_range(0, 300)) - 150;
        endcase
        if (w == 0) cmd_lft = W'(v);
        else        cmd_rht = W'(v);
      end
    end
    cmd_vld = 1'b0;
    estop   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward_ramp();
    test_reversal();
    test_to_zero();
    test_estop();
    test_saturation();
    test_tick_accept();
    test_reset_dead();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
